// File: rtl/uart_baud_timer.sv
// uart_baud_timer
// Bit-timing generator for the UART TX and RX paths. One accepted start request runs
// one frame of nb bit periods, each div sysclk cycles long. In TX mode the strobe
// fires at the start of each bit. In RX mode it fires at the bit centre.
// The divisor, the frame length and the mode are captured when the frame starts.
//
// Ports
//   sysclk      system clock
//   reset_n     asynchronous active-low reset
//   start       frame request, sampled only while idle
//   enable      gates start acceptance; when low during a frame, the frame pauses
//   abort       synchronous frame cancel, overrides everything except reset
//   mode        0 = TX (tick at bit start), 1 = RX (tick at bit centre)
//   div_val     sysclk cycles per bit (values below 2 are treated as 2)
//   num_bits    bit periods per frame (0 is treated as 1)
//   busy        high while a frame is running
//   bit_tick    one-cycle strobe per bit period
//   bit_idx     index of the current bit period
//   frame_done  one-cycle pulse after a frame completes normally
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start & enable; frame_done pulses here
// RUN   | frame in progress; cnt and bit_idx advance while enabled

module uart_baud_timer #(
   parameter int DIV_W = 16,
   parameter int NB_W  = 4
) (
   input  logic             sysclk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             enable,
   input  logic             abort,
   input  logic             mode,
   input  logic [DIV_W-1:0] div_val,
   input  logic [NB_W-1:0]  num_bits,
   output logic             busy,
   output logic             bit_tick,
   output logic [NB_W-1:0]  bit_idx,
   output logic             frame_done
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);
   localparam logic [NB_W-1:0]  NB_ONE  = NB_W'(1);

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic [NB_W-1:0]  nb;
   logic             md;

   logic [DIV_W-1:0] tick_pos;
   logic             bit_end;
   logic             last_bit;

   assign tick_pos = md ? (div >> 1) : '0;
   assign bit_end  = (cnt == div - DIV_ONE);
   assign last_bit = (bit_idx == nb - NB_ONE);

   // Gating the strobe with enable keeps it to one pulse per bit period. During a
   // pause, cnt is held on the tick position, but no strobe fires until the frame resumes.
   assign bit_tick = (state == RUN) && enable && (cnt == tick_pos);
   assign busy     = (state == RUN);

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         div        <= DIV_TWO;
         nb         <= NB_ONE;
         md         <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (abort) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && enable) begin
                     state   <= RUN;
                     cnt     <= '0;
                     bit_idx <= '0;
                     div     <= (div_val < DIV_TWO) ? DIV_TWO : div_val;
                     nb      <= (num_bits == '0) ? NB_ONE : num_bits;
                     md      <= mode;
                  end
               end
               RUN: begin
                  if (enable) begin
                     if (bit_end) begin
                        cnt <= '0;
                        if (last_bit) begin
                           state      <= IDLE;
                           bit_idx    <= '0;
                           frame_done <= 1'b1;
                        end else begin
                           bit_idx <= bit_idx + NB_ONE;
                        end
                     end else begin
                        cnt <= cnt + DIV_ONE;
                     end
                  end
               end
               default: begin
                  state   <= IDLE;
                  cnt     <= '0;
                  bit_idx <= '0;
               end
            endcase
         end
      end
   end

endmodule
